spi_xfer_engine: RTL and testbench

- Hardware SPI byte-transfer sequencer for the expansion board. It replaces the bit-banged SCK/MOSI/nSS control-code sequence with one start command per byte.
- Sits between the control-code decoder, which supplies START, TXDATA, SSSEL, HOLD and ABORT, and the SD-card/SPI pins, which are SCK, MOSI, MISO and nSS[1:0].
- RXDATA and BUSY are presented to the Gigatron bus-read mux.
- Operates in SPI mode 0 only: SCK idles low, data is sampled on the SCK rising edge, and MOSI changes on the SCK falling edge.

---
 rtl/spi_xfer_engine.sv | 173 +++++++++++++++++
 tb/tb_spi_xfer_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 byte-transfer sequencer: one START command shifts WIDTH bits out on MOSI
// and in from MISO, with programmable SCK half-period and optional held slave select.
`timescale 1ns/1ps
module spi_xfer_engine #(
    parameter int CLKDIV = 2,
    parameter int WIDTH  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] TXDATA,
    input  logic [1:0]       SSSEL,
    input  logic             HOLD,
    input  logic             ABORT,
    input  logic             MISO,
    output logic             SCK,
    output logic             MOSI,
    output logic [1:0]       nSS,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RXDATA
);

    localparam int              BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]      PH_END  = 8'(CLKDIV - 1);
    localparam logic [BW-1:0]   BIT_END = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCKHI, SCKLO} state_t;

    state_t           state, state_n;
    logic [7:0]       ph, ph_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic             last, last_n;
    logic             hold_q, hold_n;
    logic [WIDTH-1:0] txsr, txsr_n;
    logic [WIDTH-1:0] rxsr, rxsr_n;
    logic [WIDTH-1:0] rxdata_n;
    logic             sck_n, mosi_n, busy_n, done_n;
    logic [1:0]       nss_n;
    logic             ph_done;

    assign ph_done = (ph == PH_END);

    always_comb begin
        state_n  = state;
        ph_n     = ph;
        bitcnt_n = bitcnt;
        last_n   = last;
        hold_n   = hold_q;
        txsr_n   = txsr;
        rxsr_n   = rxsr;
        rxdata_n = RXDATA;
        sck_n    = SCK;
        mosi_n   = MOSI;
        nss_n    = nSS;
        busy_n   = BUSY;
        done_n   = 1'b0;

        if (ABORT) begin
            state_n  = IDLE;
            ph_n     = 8'd0;
            bitcnt_n = '0;
            last_n   = 1'b0;
            sck_n    = 1'b0;
            mosi_n   = 1'b1;
            nss_n    = 2'b11;
            busy_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The DONE cycle is a dead cycle: a START seen with DONE high is dropped.
                    if (START && !DONE) begin
                        txsr_n   = TXDATA;
                        hold_n   = HOLD;
                        nss_n    = SSSEL;
                        mosi_n   = TXDATA[WIDTH-1];
                        busy_n   = 1'b1;
                        ph_n     = 8'd0;
                        bitcnt_n = '0;
                        last_n   = 1'b0;
                        state_n  = SETUP;
                    end
                end
                SETUP: begin
                    if (ph_done) begin
                        state_n = SCKHI;
                        ph_n    = 8'd0;
                        sck_n   = 1'b1;
                        rxsr_n  = {rxsr[WIDTH-2:0], MISO};
                    end else begin
                        ph_n = ph + 8'd1;
                    end
                end
                SCKHI: begin
                    if (ph_done) begin
                        state_n = SCKLO;
                        ph_n    = 8'd0;
                        sck_n   = 1'b0;
                        // The last falling edge leaves MOSI alone and arms the finish.
                        if (bitcnt != BIT_END) begin
                            txsr_n   = {txsr[WIDTH-2:0], 1'b0};
                            mosi_n   = txsr[WIDTH-2];
                            bitcnt_n = bitcnt + BW'(1);
                        end else begin
                            last_n = 1'b1;
                        end
                    end else begin
                        ph_n = ph + 8'd1;
                    end
                end
                SCKLO: begin
                    if (ph_done) begin
                        ph_n = 8'd0;
                        if (last) begin
                            state_n  = IDLE;
                            bitcnt_n = '0;
                            last_n   = 1'b0;
                            rxdata_n = rxsr;
                            done_n   = 1'b1;
                            busy_n   = 1'b0;
                            mosi_n   = 1'b1;
                            if (!hold_q) begin
                                nss_n = 2'b11;
                            end
                        end else begin
                            state_n = SCKHI;
                            sck_n   = 1'b1;
                            rxsr_n  = {rxsr[WIDTH-2:0], MISO};
                        end
                    end else begin
                        ph_n = ph + 8'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            ph     <= 8'd0;
            bitcnt <= '0;
            last   <= 1'b0;
            hold_q <= 1'b0;
            txsr   <= '0;
            rxsr   <= '0;
            RXDATA <= '0;
            SCK    <= 1'b0;
            MOSI   <= 1'b1;
            nSS    <= 2'b11;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_n;
            ph     <= ph_n;
            bitcnt <= bitcnt_n;
            last   <= last_n;
            hold_q <= hold_n;
            txsr   <= txsr_n;
            rxsr   <= rxsr_n;
            RXDATA <= rxdata_n;
            SCK    <= sck_n;
            MOSI   <= mosi_n;
            nSS    <= nss_n;
            BUSY   <= busy_n;
            DONE   <= done_n;
        end
    end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Scoreboard bench for spi_xfer_engine: directed transfers push expected results,
// DONE monitors pop and compare.
`timescale 1ns/1ps
module tb_spi_xfer_engine;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic       start = 1'b0, abort = 1'b0, hold = 1'b0, miso_fix = 1'b0, loop = 1'b1;
    logic [7:0] txdata = 8'h00;
    logic [1:0] sssel = 2'b11;
    logic       miso, sck, mosi, busy, done;
    logic [1:0] nss;
    logic [7:0] rxdata;
    assign miso = loop ? mosi : miso_fix;

    logic       start1 = 1'b0;
    logic [7:0] txdata1 = 8'h00;
    logic       sck1, mosi1, busy1, done1;
    logic [1:0] nss1;
    logic [7:0] rxdata1;

    spi_xfer_engine #(.CLKDIV(2), .WIDTH(8)) u_dut (
        .CLK(CLK), .RST(RST), .START(start), .TXDATA(txdata), .SSSEL(sssel),
        .HOLD(hold), .ABORT(abort), .MISO(miso), .SCK(sck), .MOSI(mosi),
        .nSS(nss), .BUSY(busy), .DONE(done), .RXDATA(rxdata)
    );

    spi_xfer_engine #(.CLKDIV(1), .WIDTH(8)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(start1), .TXDATA(txdata1), .SSSEL(2'b10),
        .HOLD(1'b0), .ABORT(1'b0), .MISO(mosi1), .SCK(sck1), .MOSI(mosi1),
        .nSS(nss1), .BUSY(busy1), .DONE(done1), .RXDATA(rxdata1)
    );

    typedef struct {
        logic [7:0] rx;
        logic [1:0] nss;
        int         cyc;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_checks = 0, n_fail = 0;
    int         cyc = 0, sck_cnt = 0, done_cnt = 0, nss_glitch = 0;
    logic [7:0] mosi_bits = 8'h00;
    logic       hold_watch = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge sck) begin
        sck_cnt   <= sck_cnt + 1;
        mosi_bits <= {mosi_bits[6:0], mosi};
    end

    always @(negedge CLK) begin
        exp_t e;
        if (hold_watch && nss !== 2'b01) nss_glitch <= nss_glitch + 1;
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0_unexpected_done: rxdata 0x%0h with no transfer outstanding", rxdata);
            end else begin
                e = q0.pop_front();
                chk("dut0_rxdata", rxdata, e.rx);
                chk("dut0_done_cycle", cyc, e.cyc);
                chk("dut0_nss_at_done", nss, e.nss);
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_done: rxdata 0x%0h with no transfer outstanding", rxdata1);
            end else begin
                e = q1.pop_front();
                chk("dut1_rxdata", rxdata1, e.rx);
                chk("dut1_done_cycle", cyc, e.cyc);
                chk("dut1_nss_at_done", nss1, e.nss);
            end
        end
    end

    // Called at a negedge; the accept edge is the next posedge, DONE follows 34 cycles later.
    task automatic issue(input logic [7:0] tx, input logic [1:0] sel, input logic hd,
                         input logic [7:0] exp_rx, input logic [1:0] exp_nss);
        exp_t e;
        start  = 1'b1;
        txdata = tx;
        sssel  = sel;
        hold   = hd;
        e.rx   = exp_rx;
        e.nss  = exp_nss;
        e.cyc  = cyc + 1 + 34;
        q0.push_back(e);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input logic [1:0] expnss, output int bad);
        int n;
        bad = 0;
        n   = 0;
        while (busy === 1'b1 && n < 200) begin
            if (nss !== expnss) bad++;
            @(negedge CLK);
            n++;
        end
        chk({name, "_busy_timeout"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, bad, dc, n;
        exp_t e1;

        repeat (3) @(negedge CLK);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b1);
        chk("rst_nss", nss, 2'b11);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rxdata", rxdata, 8'h00);
        chk("rst_dut1_nss", nss1, 2'b11);
        RST = 1'b0;
        @(negedge CLK);

        // Loopback 0xA5 on select 2'b10
        loop = 1'b1;
        b = sck_cnt;
        issue(8'hA5, 2'b10, 1'b0, 8'hA5, 2'b11);
        chk("t1_nss_accept", nss, 2'b10);
        chk("t1_busy_accept", busy, 1'b1);
        chk("t1_mosi_first", mosi, 1'b1);
        wait_idle("t1", 2'b10, bad);
        chk("t1_nss_during", bad, 0);
        chk("t1_sck_edges", sck_cnt - b, 8);
        chk("t1_mosi_bits", mosi_bits, 8'hA5);
        chk("t1_mosi_after", mosi, 1'b1);
        chk("t1_nss_after", nss, 2'b11);
        @(negedge CLK);

        // Dummy clocks: no select, MISO high, all-zero TX
        loop = 1'b0;
        miso_fix = 1'b1;
        b = sck_cnt;
        issue(8'h00, 2'b11, 1'b0, 8'hFF, 2'b11);
        chk("t2_busy_accept", busy, 1'b1);
        wait_idle("t2", 2'b11, bad);
        chk("t2_nss_during", bad, 0);
        chk("t2_sck_edges", sck_cnt - b, 8);
        chk("t2_mosi_bits", mosi_bits, 8'h00);
        chk("t2_mosi_after", mosi, 1'b1);
        loop = 1'b1;
        @(negedge CLK);

        // Held select across back-to-back transfers, then ABORT in IDLE releases it
        issue(8'h3C, 2'b01, 1'b1, 8'h3C, 2'b01);
        hold_watch = 1'b1;
        wait_idle("t3a", 2'b01, bad);
        chk("t3a_nss_during", bad, 0);
        start  = 1'b1;
        txdata = 8'hC3;
        @(negedge CLK);
        chk("t3_start_with_done_ignored", busy, 1'b0);
        issue(8'hC3, 2'b01, 1'b1, 8'hC3, 2'b01);
        chk("t3b_busy_accept", busy, 1'b1);
        wait_idle("t3b", 2'b01, bad);
        chk("t3b_nss_during", bad, 0);
        chk("t3b_mosi_bits", mosi_bits, 8'hC3);
        hold_watch = 1'b0;
        @(negedge CLK);
        chk("t3_nss_glitches", nss_glitch, 0);
        chk("t3_nss_held_idle", nss, 2'b01);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("t3_abort_idle_nss", nss, 2'b11);
        @(negedge CLK);

        // START re-pulse with 0xFF during a 0x12 transfer
        dc = done_cnt;
        issue(8'h12, 2'b10, 1'b0, 8'h12, 2'b11);
        repeat (9) @(negedge CLK);
        start  = 1'b1;
        txdata = 8'hFF;
        @(negedge CLK);
        start = 1'b0;
        chk("t4_busy_after_repulse", busy, 1'b1);
        wait_idle("t4", 2'b10, bad);
        chk("t4_mosi_bits", mosi_bits, 8'h12);
        @(negedge CLK);
        chk("t4_done_count", done_cnt - dc, 1);

        // ABORT mid-bit at t0+15, then START+ABORT together
        dc = done_cnt;
        start  = 1'b1;
        txdata = 8'h5A;
        sssel  = 2'b10;
        hold   = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        repeat (14) @(negedge CLK);
        chk("t5_sck_before_abort", sck, 1'b1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("t5_abort_sck", sck, 1'b0);
        chk("t5_abort_nss", nss, 2'b11);
        chk("t5_abort_busy", busy, 1'b0);
        chk("t5_abort_mosi", mosi, 1'b1);
        chk("t5_abort_rxdata", rxdata, 8'h12);
        repeat (40) @(negedge CLK);
        chk("t5_no_done", done_cnt - dc, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        chk("t5_start_abort_busy", busy, 1'b0);
        chk("t5_start_abort_nss", nss, 2'b11);
        @(negedge CLK);

        // Asynchronous reset while SCK is high
        start  = 1'b1;
        txdata = 8'h5A;
        sssel  = 2'b10;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        chk("t6_sck_high", sck, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_sck", sck, 1'b0);
        chk("t6_rst_nss", nss, 2'b11);
        chk("t6_rst_rxdata", rxdata, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // CLKDIV=1 instance: 0x81, DONE at t0+17
        start1  = 1'b1;
        txdata1 = 8'h81;
        e1.rx   = 8'h81;
        e1.nss  = 2'b11;
        e1.cyc  = cyc + 1 + 17;
        q1.push_back(e1);
        @(negedge CLK);
        start1 = 1'b0;
        chk("t7_busy_accept", busy1, 1'b1);
        chk("t7_nss_accept", nss1, 2'b10);
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("t7_busy_timeout", 32'(n < 100), 32'd1);
        chk("t7_nss_after", nss1, 2'b11);

        repeat (3) @(negedge CLK);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
